// File: rtl/pb_ctrl_pkg.sv
// Shared constants for the pushbutton edge controller: register map, edge-type encodings,
// debounce state encoding and the per-bit edge selection helper.
package pb_ctrl_pkg;

    localparam logic [1:0] PB_ADDR_DATA = 2'd0;
    localparam logic [1:0] PB_ADDR_DIR  = 2'd1;
    localparam logic [1:0] PB_ADDR_MASK = 2'd2;
    localparam logic [1:0] PB_ADDR_EDGE = 2'd3;

    localparam int PB_EDGE_RISE = 0;
    localparam int PB_EDGE_FALL = 1;
    localparam int PB_EDGE_ANY  = 2;

    typedef enum logic [0:0] {
        PB_DB_STABLE  = 1'b0,
        PB_DB_PENDING = 1'b1
    } pb_db_state_e;

    // Returns 1 when the transition prev -> cur matches the configured edge type.
    function automatic logic pb_edge_bit(input int edge_type, input logic cur, input logic prev);
        logic hit;
        case (edge_type)
            PB_EDGE_RISE: hit = cur & ~prev;
            PB_EDGE_FALL: hit = ~cur & prev;
            PB_EDGE_ANY:  hit = cur ^ prev;
            default:      hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/test_sys_top_qsys_pb_edge_ctrl_if.sv
// Avalon-MM slave bus bundle for the pushbutton controller (word-addressed, 1-cycle read latency).
interface test_sys_top_qsys_pb_edge_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

endinterface

// File: rtl/pb_debounce_bit.sv
// One pushbutton bit: 2-flop synchroniser followed by a counter debouncer.
// With PB_DEBOUNCE_EN undefined the debouncer collapses to a plain register stage.
module pb_debounce_bit
    import pb_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic in_raw,
    output logic level_o
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
        $error("pb_debounce_bit: DEBOUNCE_CYCLES must be at least 2");
    end

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic level_q, level_d;

    // Synchroniser next-state
    always_comb begin
        sync1_d = in_raw;
        sync2_d = sync1_q;
    end

    // Synchroniser and level registers; idle-high after reset so reset never looks like a press
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
        end
    end

`ifdef PB_DEBOUNCE_EN
    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    pb_db_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: level only follows the synced input after it has differed for DEBOUNCE_CYCLES cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            state_d = PB_DB_STABLE;
            cnt_d   = '0;
        end else if ((state_q == PB_DB_PENDING) && (cnt_q == CNT_LAST)) begin
            state_d = PB_DB_STABLE;
            cnt_d   = '0;
            level_d = sync2_q;
        end else begin
            state_d = PB_DB_PENDING;
            cnt_d   = (state_q == PB_DB_STABLE) ? CNT_W'(1) : (cnt_q + CNT_W'(1));
        end
    end

    // Debounce state and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PB_DB_STABLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    // Without debounce the accepted level simply trails the synchroniser by one cycle
    always_comb begin
        level_d = sync2_q;
    end
`endif

    assign level_o = level_q;

endmodule

// File: rtl/test_sys_top_qsys_pb_edge_ctrl.sv
// Avalon-MM pushbutton controller: per-bit sync/debounce, edge capture (W1C), maskable level IRQ.
// Optional feature macro: PB_DEBOUNCE_EN (counter debounce; otherwise level follows synced input).
module test_sys_top_qsys_pb_edge_ctrl
    import pb_ctrl_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = PB_EDGE_FALL
) (
    input  logic                                  clk,
    input  logic                                  reset,
    test_sys_top_qsys_pb_edge_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0]                      in_port,
    output logic                                  irq
);

    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] clr_s;
    logic             wr_s;
    logic [WIDTH-1:0] level_dly_q, level_dly_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             unused_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pb_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk),
            .reset   (reset),
            .in_raw  (in_port[i]),
            .level_o (level_s[i])
        );
    end

    // Edge detection against the one-cycle-delayed debounced level
    always_comb begin
        edge_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            edge_s[i] = pb_edge_bit(EDGE_TYPE, level_s[i], level_dly_q[i]);
        end
    end

    // Register file, edge capture, read mux and irq next-state
    always_comb begin
        wr_s        = bus.chipselect & ~bus.write_n;
        level_dly_d = level_s;

        if (wr_s && (bus.address == PB_ADDR_MASK)) begin
            irqmask_d = bus.writedata[WIDTH-1:0];
        end else begin
            irqmask_d = irqmask_q;
        end

        if (wr_s && (bus.address == PB_ADDR_EDGE)) begin
            clr_s = bus.writedata[WIDTH-1:0];
        end else begin
            clr_s = '0;
        end
        // OR-ing the new edge after the clear makes a coincident edge survive the W1C
        edgecap_d = (edgecap_q & ~clr_s) | edge_s;

        irq_d = |(edgecap_q & irqmask_q);

        readdata_d = 32'd0;
        case (bus.address)
            PB_ADDR_DATA: readdata_d[WIDTH-1:0] = level_s;
            PB_ADDR_DIR:  readdata_d            = 32'd0;
            PB_ADDR_MASK: readdata_d[WIDTH-1:0] = irqmask_q;
            PB_ADDR_EDGE: readdata_d[WIDTH-1:0] = edgecap_q;
            default:      readdata_d            = 32'd0;
        endcase
    end

    // Control/status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            level_dly_q <= '1;
            edgecap_q   <= '0;
            irqmask_q   <= '0;
            readdata_q  <= 32'd0;
            irq_q       <= 1'b0;
        end else begin
            level_dly_q <= level_dly_d;
            edgecap_q   <= edgecap_d;
            irqmask_q   <= irqmask_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
        end
    end

    assign unused_s     = ^bus.writedata;
    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule
